// File: rtl/vga_gfx_pkg.sv
// Shared constants, types and helpers for the VGA graphics peripheral
// with a palette and a double-buffered line store.
package vga_gfx_pkg;

   localparam logic [5:0] ADDR_INTCFG  = 6'h01;
   localparam logic [5:0] ADDR_YPOS    = 6'h02;
   localparam logic [5:0] ADDR_CTRL    = 6'h03;
   localparam logic [5:0] ADDR_PALIDX  = 6'h05;
   localparam logic [5:0] ADDR_PALDATA = 6'h06;
   localparam logic [5:0] ADDR_STATUS  = 6'h07;

   localparam logic [1:0] WR_BYTE = 2'b00;
   localparam logic [1:0] WR_HALF = 2'b01;
   localparam logic [1:0] WR_WORD = 2'b10;
   localparam logic [1:0] WR_NONE = 2'b11;

   typedef logic [5:0] colour_t;

   typedef enum logic {
      SWAP_IDLE,
      SWAP_PENDING
   } swap_state_t;

   function automatic int unsigned npix(input int unsigned buf_words, input int unsigned bpp);
      return buf_words * 32 / bpp;
   endfunction

endpackage

// File: rtl/vga_gfx_dbuf.sv
// Two pixel buffers: the CPU writes/reads the back one while the
// display reads the front one; swap toggles which is which.
module vga_gfx_dbuf
   import vga_gfx_pkg::*;
#(
   parameter  int unsigned BPP       = 2,
   parameter  int unsigned BUF_WORDS = 16,
   localparam int unsigned WORD_W    = $clog2(BUF_WORDS),
   localparam int unsigned PIX_W     = $clog2(npix(BUF_WORDS, BPP))
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [1:0]        wr_size,
   input  logic [WORD_W-1:0] word,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   input  logic              swap,
   input  logic [PIX_W-1:0]  pix,
   output logic [BPP-1:0]    pix_idx,
   output logic              front
);

   localparam int unsigned PPW_LOG2 = $clog2(32 / BPP);

   logic [31:0] mem [2][BUF_WORDS];
   logic        back;
   logic [31:0] front_word;
   logic [4:0]  bit_ofs;

   assign back = ~front;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned w = 0; w < BUF_WORDS; w++) begin
            mem[0][w] <= '0;
            mem[1][w] <= '0;
         end
         front <= 1'b0;
      end else begin
         if (wr_en) begin
            case (wr_size)
               WR_BYTE: mem[back][word][7:0]  <= wr_data[7:0];
               WR_HALF: mem[back][word][15:0] <= wr_data[15:0];
               default: mem[back][word]       <= wr_data;
            endcase
         end
         if (swap) front <= ~front;
      end
   end

   // Pixel 0 sits in the LSBs of word 0; upper pixel bits pick the word.
   always_comb begin
      rd_data    = mem[back][word];
      front_word = mem[front][pix[PIX_W-1 -: WORD_W]];
      bit_ofs    = 5'(32'(pix[PPW_LOG2-1:0]) * BPP);
      pix_idx    = front_word[bit_ofs +: BPP];
   end

endmodule

// File: rtl/vga_timing_gfx.sv
// 1024x768 timing generator at 64 MHz; y is split into y_hi/y_lo
// so software can read the line number in two fields.
module vga_timing_gfx (
   input  logic        clk,
   input  logic        rst_n,
   output logic [10:0] x,
   output logic [4:0]  y_hi,
   output logic [5:0]  y_lo,
   output logic        hsync,
   output logic        vsync,
   output logic        blank
);

   localparam logic [10:0] H_ACTIVE = 11'd1024;
   localparam logic [10:0] H_SYNC_S = 11'd1048;
   localparam logic [10:0] H_SYNC_E = 11'd1184;
   localparam logic [10:0] H_TOTAL  = 11'd1344;
   localparam logic [10:0] V_ACTIVE = 11'd768;
   localparam logic [10:0] V_SYNC_S = 11'd771;
   localparam logic [10:0] V_SYNC_E = 11'd777;
   localparam logic [10:0] V_TOTAL  = 11'd806;

   logic [10:0] y;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (x == H_TOTAL - 11'd1) begin
         x <= '0;
         y <= (y == V_TOTAL - 11'd1) ? '0 : y + 11'd1;
      end else begin
         x <= x + 11'd1;
      end
   end

   always_comb begin
      y_hi  = y[10:6];
      y_lo  = y[5:0];
      blank = (x >= H_ACTIVE) || (y >= V_ACTIVE);
      hsync = !((x >= H_SYNC_S) && (x < H_SYNC_E));
      vsync = !((y >= V_SYNC_S) && (y < V_SYNC_E));
   end

endmodule

// File: rtl/vga_gfx_pal_dbuf.sv
// TinyQV VGA graphics peripheral: palette lookup of a double-buffered
// pixel line, runtime pixel width, swap-in-blank and line/swap interrupts.
module vga_gfx_pal_dbuf
   import vga_gfx_pkg::*;
#(
   parameter int unsigned BPP          = 2,
   parameter int unsigned BUF_WORDS    = 16,
   parameter int unsigned PIX_LOG2_RST = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam int unsigned NPIX   = npix(BUF_WORDS, BPP);
   localparam int unsigned WORD_W = $clog2(BUF_WORDS);
   localparam int unsigned PIX_W  = $clog2(NPIX);

   logic [10:0] vga_x;
   logic [4:0]  vga_y_hi;
   logic [5:0]  vga_y_lo;
   logic        hsync, vsync, blank;

   logic [7:0]     cfg;
   logic [1:0]     pix_log2;
   logic [BPP-1:0] pal_idx;
   colour_t        palette [2**BPP];
   logic [BPP-1:0] idx_r;
   logic           hsync_r, vsync_r;
   logic           line_irq, swap_irq;
   swap_state_t    state, state_nx;
   logic           do_swap, swap_pending;

   logic           wr, rd, buf_sel, buf_wr, line_hit, status_clr;
   logic [10:0]    p;
   logic [BPP-1:0] pix_idx;
   logic [31:0]    back_word;
   logic           front;
   colour_t        colour;
   logic           unused_ok;

   assign unused_ok  = &{1'b0, ui_in};
   assign data_ready = 1'b1;

   vga_timing_gfx u_timing (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (vga_x),
      .y_hi  (vga_y_hi),
      .y_lo  (vga_y_lo),
      .hsync (hsync),
      .vsync (vsync),
      .blank (blank)
   );

   vga_gfx_dbuf #(
      .BPP       (BPP),
      .BUF_WORDS (BUF_WORDS)
   ) u_dbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (buf_wr),
      .wr_size (data_write_n),
      .word    (address[2 +: WORD_W]),
      .wr_data (data_in),
      .rd_data (back_word),
      .swap    (do_swap),
      .pix     (p[PIX_W-1:0]),
      .pix_idx (pix_idx),
      .front   (front)
   );

   always_comb begin
      wr         = (data_write_n != WR_NONE);
      rd         = (data_read_n != 2'b11);
      buf_sel    = (address[1:0] == 2'b00) && (32'(address[5:2]) < BUF_WORDS);
      buf_wr     = wr && buf_sel;
      status_clr = rd && (address == ADDR_STATUS);
      p          = vga_x >> pix_log2;
      line_hit   = cfg[6] && ((vga_y_lo[3:0] | cfg[3:0]) == 4'hF) &&
                   (vga_x == {cfg[5:4] == 2'b00, cfg[5:4], 8'h00});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg      <= '0;
         pix_log2 <= 2'(PIX_LOG2_RST);
         pal_idx  <= '0;
         for (int unsigned i = 0; i < 2**BPP; i++) palette[i] <= '0;
         idx_r    <= '0;
         hsync_r  <= 1'b0;
         vsync_r  <= 1'b0;
         line_irq <= 1'b0;
         swap_irq <= 1'b0;
      end else begin
         if (wr && address == ADDR_INTCFG) cfg <= data_in[7:0];
         if (wr && address == ADDR_CTRL)   pix_log2 <= data_in[3:2];
         if (wr && address == ADDR_PALIDX) pal_idx <= data_in[BPP-1:0];
         if (wr && address == ADDR_PALDATA) begin
            palette[pal_idx] <= data_in[5:0];
            pal_idx          <= pal_idx + 1'b1;
         end
         idx_r   <= (blank || 32'(p) >= NPIX) ? '0 : pix_idx;
         hsync_r <= hsync;
         vsync_r <= vsync;
         // A new event on the clearing edge must survive the clear.
         line_irq <= line_hit | (line_irq & ~status_clr);
         swap_irq <= (do_swap & cfg[7]) | (swap_irq & ~status_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= SWAP_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SWAP_IDLE:    if (wr && address == ADDR_CTRL && data_in[0]) state_nx = SWAP_PENDING;
         SWAP_PENDING: if (blank) state_nx = SWAP_IDLE;
         default:      state_nx = SWAP_IDLE;
      endcase
   end

   always_comb begin
      swap_pending = (state == SWAP_PENDING);
      do_swap      = swap_pending && blank;
   end

   always_comb begin
      colour         = palette[idx_r];
      uo_out         = {hsync_r, colour[0], colour[2], colour[4],
                        vsync_r, colour[1], colour[3], colour[5]};
      user_interrupt = line_irq | swap_irq;
   end

   always_comb begin
      data_out = '0;
      if (buf_sel) begin
         data_out = back_word;
      end else begin
         case (address)
            ADDR_INTCFG:  data_out = {24'b0, cfg};
            ADDR_YPOS:    data_out = {18'b0, vga_y_hi, 3'b0, vga_y_lo};
            ADDR_CTRL:    data_out = {26'b0, front, swap_pending, pix_log2, 2'b00};
            ADDR_PALIDX:  data_out = 32'(pal_idx);
            ADDR_PALDATA: data_out = {26'b0, palette[pal_idx]};
            ADDR_STATUS:  data_out = {30'b0, swap_irq, line_irq};
            default:      data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_gfx_pal_dbuf.sv
// Directed self-checking bench for vga_gfx_pal_dbuf (BPP=2, 16 words).
module tb_vga_gfx_pal_dbuf;

   localparam int H_TOTAL = 1344;
   localparam int V_TOTAL = 806;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ui_in = 8'h00;
   logic [7:0]  uo_out;
   logic [5:0]  address = 6'h00;
   logic [31:0] data_in = 32'h0;
   logic [1:0]  data_write_n = 2'b11;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int          n_pass = 0;
   int          n_total = 0;
   int unsigned cyc = 0;
   logic [31:0] rd;

   vga_gfx_pal_dbuf #(
      .BPP          (2),
      .BUF_WORDS    (16),
      .PIX_LOG2_RST (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt)
   );

   always #5 clk = ~clk;

   // Beam position model: counts non-reset edges.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic int mx();
      return int'(cyc % H_TOTAL);
   endfunction

   function automatic int my();
      return int'((cyc / H_TOTAL) % V_TOTAL);
   endfunction

   function automatic logic [5:0] col(input logic [7:0] u);
      return {u[0], u[4], u[1], u[5], u[2], u[6]};
   endfunction

   // Bus tasks start and end on a falling edge.
   task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
      address = a; data_in = d; data_write_n = wn;
      @(negedge clk);
      data_write_n = 2'b11;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      address = a; data_read_n = 2'b00;
      #1 d = data_out;
      @(negedge clk);
      data_read_n = 2'b11;
   endtask

   task automatic wait_x(input int x);
      int n = 0;
      do begin @(negedge clk); n++; end while (mx() != x && n < 2 * H_TOTAL);
      if (mx() != x) begin
         n_total++;
         $display("FAIL wait_x: reached x=%0d, required x=%0d", mx(), x);
      end
   endtask

   task automatic wait_yx(input int ym, input int x);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!((my() % 4) == ym && mx() == x) && n < 6 * H_TOTAL);
      if (!((my() % 4) == ym && mx() == x)) begin
         n_total++;
         $display("FAIL wait_yx: reached y=%0d x=%0d, required y%%4=%0d x=%0d", my(), mx(), ym, x);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      n_total++; if (uo_out !== 8'h00) $display("FAIL reset_uo: got %h want 00", uo_out); else n_pass++;
      n_total++; if (user_interrupt !== 1'b0) $display("FAIL reset_irq: got %b want 0", user_interrupt); else n_pass++;
      n_total++; if (data_ready !== 1'b1) $display("FAIL data_ready: got %b want 1", data_ready); else n_pass++;
      rst_n = 1'b1;
      bus_read(6'h03, rd);
      n_total++; if (rd !== 32'h08) $display("FAIL reset_ctrl: got %h want 00000008", rd); else n_pass++;
      n_total++; if (col(uo_out) !== 6'h00) $display("FAIL reset_colour: got %h want 00", col(uo_out)); else n_pass++;
   endtask

   task automatic test_palette();
      bus_write(6'h05, 32'h3, 2'b00);
      bus_write(6'h06, 32'h3F, 2'b00);
      bus_write(6'h06, 32'h01, 2'b00);
      bus_read(6'h05, rd);
      n_total++; if (rd !== 32'h1) $display("FAIL pal_idx_wrap: got %h want 00000001", rd); else n_pass++;
      bus_write(6'h05, 32'h3, 2'b00);
      bus_read(6'h06, rd);
      n_total++; if (rd !== 32'h3F) $display("FAIL pal3: got %h want 0000003f", rd); else n_pass++;
      bus_write(6'h05, 32'h0, 2'b00);
      bus_read(6'h06, rd);
      n_total++; if (rd !== 32'h01) $display("FAIL pal0: got %h want 00000001", rd); else n_pass++;
      bus_write(6'h05, 32'h1, 2'b00);
      bus_write(6'h06, 32'h2A, 2'b00);
      bus_write(6'h06, 32'h15, 2'b00);
      bus_read(6'h05, rd);
      n_total++; if (rd !== 32'h3) $display("FAIL pal_idx_inc: got %h want 00000003", rd); else n_pass++;
      // Front buffer is all zero, so palette[0] is on screen.
      n_total++; if (col(uo_out) !== 6'h01) $display("FAIL pal0_screen: got %h want 01", col(uo_out)); else n_pass++;
   endtask

   task automatic test_regs();
      int y;
      bus_write(6'h04, 32'hAAAA_AAAA, 2'b10);
      bus_write(6'h04, 32'h1234_5655, 2'b00);
      bus_read(6'h04, rd);
      n_total++; if (rd !== 32'hAAAA_AA55) $display("FAIL byte_write: got %h want aaaaaa55", rd); else n_pass++;
      bus_write(6'h04, 32'h5678_1234, 2'b01);
      bus_read(6'h04, rd);
      n_total++; if (rd !== 32'hAAAA_1234) $display("FAIL half_write: got %h want aaaa1234", rd); else n_pass++;
      bus_read(6'h0B, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL unmapped: got %h want 00000000", rd); else n_pass++;
      bus_write(6'h01, 32'hA5, 2'b00);
      bus_read(6'h01, rd);
      n_total++; if (rd !== 32'hA5) $display("FAIL cfg_rd: got %h want 000000a5", rd); else n_pass++;
      bus_write(6'h01, 32'h00, 2'b00);
      y = my();
      bus_read(6'h02, rd);
      n_total++;
      if (rd !== (((y >> 6) << 9) | (y & 63))) $display("FAIL ypos: got %h want %h", rd, ((y >> 6) << 9) | (y & 63));
      else n_pass++;
   endtask

   task automatic test_pixel_map();
      int          xs [7] = '{1, 4, 5, 9, 13, 1021, 1025};
      logic [5:0]  es [7] = '{6'h01, 6'h01, 6'h2A, 6'h15, 6'h3F, 6'h3F, 6'h01};
      bus_write(6'h00, 32'h0000_00E4, 2'b10);
      bus_write(6'h3C, 32'hFFFF_FFFF, 2'b10);
      wait_x(100);
      bus_write(6'h03, 32'h09, 2'b00);
      wait_x(1030);
      bus_read(6'h03, rd);
      n_total++; if (rd !== 32'h28) $display("FAIL swap1_ctrl: got %h want 00000028", rd); else n_pass++;
      for (int i = 0; i < 7; i++) begin
         wait_x(xs[i]);
         n_total++;
         if (col(uo_out) !== es[i]) $display("FAIL pix_x%0d: got %h want %h", xs[i] - 1, col(uo_out), es[i]);
         else n_pass++;
      end
      bus_write(6'h03, 32'h00, 2'b00);
      wait_x(2);
      n_total++; if (col(uo_out) !== 6'h2A) $display("FAIL pw0_x1: got %h want 2a", col(uo_out)); else n_pass++;
      wait_x(256);
      n_total++; if (col(uo_out) !== 6'h3F) $display("FAIL pw0_x255: got %h want 3f", col(uo_out)); else n_pass++;
      wait_x(257);
      n_total++; if (col(uo_out) !== 6'h01) $display("FAIL pw0_x256: got %h want 01", col(uo_out)); else n_pass++;
      bus_write(6'h03, 32'h08, 2'b00);
   endtask

   task automatic test_double_buffer();
      bus_write(6'h01, 32'h80, 2'b00);
      wait_x(100);
      bus_write(6'h00, 32'h0000_001B, 2'b10);
      wait_x(1);
      n_total++; if (col(uo_out) !== 6'h01) $display("FAIL db_hold_x0: got %h want 01", col(uo_out)); else n_pass++;
      wait_x(200);
      bus_write(6'h03, 32'h09, 2'b00);
      bus_write(6'h03, 32'h09, 2'b00);
      bus_read(6'h03, rd);
      n_total++; if (rd !== 32'h38) $display("FAIL db_pending: got %h want 00000038", rd); else n_pass++;
      n_total++; if (user_interrupt !== 1'b0) $display("FAIL db_irq_early: got %b want 0", user_interrupt); else n_pass++;
      wait_x(1021);
      n_total++; if (col(uo_out) !== 6'h3F) $display("FAIL db_hold_x1020: got %h want 3f", col(uo_out)); else n_pass++;
      wait_x(1030);
      bus_read(6'h03, rd);
      n_total++; if (rd !== 32'h08) $display("FAIL db_swapped: got %h want 00000008", rd); else n_pass++;
      n_total++; if (user_interrupt !== 1'b1) $display("FAIL db_irq: got %b want 1", user_interrupt); else n_pass++;
      bus_read(6'h07, rd);
      n_total++; if (rd !== 32'h02) $display("FAIL db_status: got %h want 00000002", rd); else n_pass++;
      n_total++; if (user_interrupt !== 1'b0) $display("FAIL db_irq_clr: got %b want 0", user_interrupt); else n_pass++;
      wait_x(1);
      n_total++; if (col(uo_out) !== 6'h3F) $display("FAIL db_new_x0: got %h want 3f", col(uo_out)); else n_pass++;
      wait_x(5);
      n_total++; if (col(uo_out) !== 6'h15) $display("FAIL db_new_x4: got %h want 15", col(uo_out)); else n_pass++;
      wait_x(1021);
      n_total++; if (col(uo_out) !== 6'h01) $display("FAIL db_new_x1020: got %h want 01", col(uo_out)); else n_pass++;
   endtask

   task automatic test_swap_in_blank();
      wait_x(1100);
      bus_write(6'h03, 32'h09, 2'b00);
      bus_read(6'h03, rd);
      n_total++; if (rd !== 32'h18) $display("FAIL blank_same_edge: got %h want 00000018", rd); else n_pass++;
      bus_read(6'h03, rd);
      n_total++; if (rd !== 32'h28) $display("FAIL blank_next_edge: got %h want 00000028", rd); else n_pass++;
      bus_read(6'h07, rd);
      n_total++; if (rd !== 32'h02) $display("FAIL blank_status: got %h want 00000002", rd); else n_pass++;
   endtask

   task automatic test_line_irq();
      bus_write(6'h01, 32'h5C, 2'b00);
      wait_yx(3, 16'h110);
      bus_read(6'h07, rd);
      wait_yx(2, 16'h180);
      bus_read(6'h07, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL line_masked: got %h want 00000000", rd); else n_pass++;
      wait_yx(3, 16'h100);
      n_total++; if (user_interrupt !== 1'b0) $display("FAIL line_before: got %b want 0", user_interrupt); else n_pass++;
      wait_x(16'h101);
      n_total++; if (user_interrupt !== 1'b1) $display("FAIL line_fire: got %b want 1", user_interrupt); else n_pass++;
      bus_read(6'h07, rd);
      n_total++; if (rd !== 32'h01) $display("FAIL line_status: got %h want 00000001", rd); else n_pass++;
      n_total++; if (user_interrupt !== 1'b0) $display("FAIL line_clr: got %b want 0", user_interrupt); else n_pass++;
   endtask

   task automatic test_collision();
      wait_yx(3, 16'h100);
      bus_read(6'h07, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL coll_read: got %h want 00000000", rd); else n_pass++;
      n_total++; if (user_interrupt !== 1'b1) $display("FAIL coll_irq: got %b want 1", user_interrupt); else n_pass++;
      bus_read(6'h07, rd);
      n_total++; if (rd !== 32'h01) $display("FAIL coll_status: got %h want 00000001", rd); else n_pass++;
      n_total++; if (user_interrupt !== 1'b0) $display("FAIL coll_clr: got %b want 0", user_interrupt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_palette();
      test_regs();
      test_pixel_map();
      test_double_buffer();
      test_swap_in_blank();
      test_line_irq();
      test_collision();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
